uks_channel_switch: RTL
=======================

UKS_CHANNEL_SWITCH -- requirements
Module: uks_channel_switch

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of module channels (M1..M16).
REQ-002 SHALL have parameter STABLE_CYC, default 16, cycles the address must hold unchanged before it is accepted.
REQ-003 SHALL have parameter GUARD_CYC, default 64, idle cycles inserted on every channel switch.
REQ-004 SHALL have parameter IDLE_LVL, default 1'b1, line level driven on unselected and guarded outputs.
REQ-005 SHALL have port clk_50_MHz, in, 1, single clock for all logic; NRESET, in, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port addr_in, in, 8, "Упр" address; [3:0] channel, [7:4] its bitwise complement.
REQ-007 SHALL have ports din_osn and din_rez, in, 1 each, main and reserve serial data from the "Упр" connector.
REQ-008 SHALL have ports dout_osn and dout_rez, out, NUM_CH each, serial data to modules.
REQ-009 SHALL have ports mod_din_osn and mod_din_rez, in, NUM_CH each, serial data returned by modules.
REQ-010 SHALL have ports dataout_osn and dataout_rez, out, 1 each, selected module's return data to "Упр".
REQ-011 SHALL have port sel_ch, out, 4, active channel index; sel_valid, out, 1, high in ACTIVE only.
REQ-012 SHALL have port switching, out, 1, high in GUARD; addr_err, out, 1, one-cycle pulse on a rejected address.
REQ-013 SHALL have port activity, out, NUM_CH, per-channel return-line activity flags (REQ-031).

Function
REQ-014 SHALL pass addr_in, din_*, and mod_din_* through 2-flop synchronizers before use.
REQ-015 SHALL accept an address only after the synchronized value is unchanged for STABLE_CYC consecutive cycles; any change restarts the count.
REQ-016 SHALL treat an accepted address as valid iff [7:4] == ~[3:0]; the target channel is [3:0].
REQ-017 SHALL evaluate each accepted address once per change, not repeatedly while it is held.
REQ-018 SHALL implement an FSM with states IDLE, GUARD, and ACTIVE.
REQ-019 IDLE SHALL go to GUARD on a valid accepted address, loading target and guard counter = GUARD_CYC-1.
REQ-020 GUARD SHALL decrement the counter each cycle and go to ACTIVE on the cycle the counter is 0, latching sel_ch = target.
REQ-021 GUARD SHALL reload target and counter on a new valid address, and go to IDLE on an invalid one.
REQ-022 ACTIVE SHALL go to GUARD on a valid address differing from sel_ch, ignore an equal one, and go to IDLE on an invalid one.
REQ-023 SHALL pulse addr_err for exactly one cycle on each invalid accepted address, in any state.
REQ-024 In ACTIVE, SHALL drive dout_osn[sel_ch] = synced din_osn and dout_rez[sel_ch] = synced din_rez, with all other bits at IDLE_LVL.
REQ-025 In ACTIVE, SHALL drive dataout_osn/rez = synced mod_din_osn/rez[sel_ch].
REQ-026 In IDLE and GUARD, SHALL drive all dout_* and dataout_* to IDLE_LVL.
REQ-027 All data outputs SHALL be registered, with 3-cycle latency from input pin to output (2 sync stages + 1 output stage).
REQ-028 Never more than one channel SHALL carry data in any cycle; the switch path SHALL always pass through GUARD.

Reset
REQ-029 NRESET low SHALL asynchronously force IDLE, sel_ch=0, sel_valid=0, switching=0, addr_err=0, activity=0, and dout_*/dataout_*=IDLE_LVL.
REQ-030 SHALL clear the stability counter and synchronizers on reset, and require STABLE_CYC after release before any acceptance, including reset asserted mid-GUARD or mid-ACTIVE.

Configuration
REQ-031 With UKS_ACTIVITY_EN defined, SHALL set activity[i] at the end of each 50000-cycle (1 ms) window iff at least one edge occurred on synced mod_din_osn[i] or mod_din_rez[i] during that window, and hold the flag until the next window ends.
REQ-032 Without UKS_ACTIVITY_EN, SHALL tie activity to 0 and synthesize no window counter or edge detectors.

Verification
REQ-033 Reset release, then addr_in=8'hE1 held: GUARD 16+2 cycles later, ACTIVE after 64 more cycles, sel_ch=1, and din_osn toggles appear on dout_osn[1] only, 3 cycles later.
REQ-034 ACTIVE ch1, addr_in→8'h5A: sel_valid falls, all outputs go to IDLE_LVL for 64 cycles, then sel_ch=10 with data on bit 10.
REQ-035 addr_in=8'h12 (bad complement) held 16 cycles: exactly one addr_err pulse, FSM goes to IDLE, all outputs 1.
REQ-036 addr_in glitches 8'hE1→8'hD2 every 10 cycles: no acceptance, and state and outputs stay unchanged.
REQ-037 NRESET pulsed low mid-GUARD: immediate IDLE with outputs at idle level, and no acceptance earlier than 18 cycles after release.
REQ-038 UKS_ACTIVITY_EN defined, one edge on mod_din_rez[5]: activity=16'h0020 after the window ends, and 0 after the next quiet window.

Source files
------------

// File: rtl/uks_channel_switch.sv
`default_nettype none
// ============================================================================
// Module   : uks_channel_switch
// Brief    : Address-selected 1-of-NUM_CH serial channel switch with stability
//            filter and guard gap. Optional macro UKS_ACTIVITY_EN adds
//            per-channel return-line activity flags.
// Revision : 1.0 - initial release
// ============================================================================
module uks_channel_switch #(
    parameter int   NUM_CH     = 16,
    parameter int   STABLE_CYC = 16,
    parameter int   GUARD_CYC  = 64,
    parameter logic IDLE_LVL   = 1'b1,
    parameter int   WIN_CYC    = 50000
) (
    input  logic              clk_50_MHz,
    input  logic              NRESET,
    input  logic [7:0]        addr_in,
    input  logic              din_osn,
    input  logic              din_rez,
    output logic [NUM_CH-1:0] dout_osn,
    output logic [NUM_CH-1:0] dout_rez,
    input  logic [NUM_CH-1:0] mod_din_osn,
    input  logic [NUM_CH-1:0] mod_din_rez,
    output logic              dataout_osn,
    output logic              dataout_rez,
    output logic [3:0]        sel_ch,
    output logic              sel_valid,
    output logic              switching,
    output logic              addr_err,
    output logic [NUM_CH-1:0] activity
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [SW-1:0] STAB_DONE  = SW'(STABLE_CYC);
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYC - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GUARD  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    logic [7:0]        r_addr_m, r_addr_s;
    logic              r_dino_m, r_dino_s, r_dinr_m, r_dinr_s;
    logic [NUM_CH-1:0] r_modo_m, r_modo_s, r_modr_m, r_modr_s;

    always_ff @(posedge clk_50_MHz or negedge NRESET) begin
        if (!NRESET) begin
            r_addr_m <= '0;
            r_addr_s <= '0;
            r_dino_m <= 1'b0;
            r_dino_s <= 1'b0;
            r_dinr_m <= 1'b0;
            r_dinr_s <= 1'b0;
            r_modo_m <= '0;
            r_modo_s <= '0;
            r_modr_m <= '0;
            r_modr_s <= '0;
        end else begin
            r_addr_m <= addr_in;
            r_addr_s <= r_addr_m;
            r_dino_m <= din_osn;
            r_dino_s <= r_dino_m;
            r_dinr_m <= din_rez;
            r_dinr_s <= r_dinr_m;
            r_modo_m <= mod_din_osn;
            r_modo_s <= r_modo_m;
            r_modr_m <= mod_din_rez;
            r_modr_s <= r_modr_m;
        end
    end

    // Change seen one stage early so the count restarts on the same edge the
    // new value lands; saturation at STAB_DONE gives one evaluation per change.
    logic [SW-1:0] r_stab;
    logic          w_addr_chg, w_accept, w_valid;

    assign w_addr_chg = (r_addr_m != r_addr_s);
    assign w_accept   = !w_addr_chg && (r_stab == STAB_LAST);
    assign w_valid    = (r_addr_s[7:4] == ~r_addr_s[3:0]);

    always_ff @(posedge clk_50_MHz or negedge NRESET) begin
        if (!NRESET)
            r_stab <= '0;
        else if (w_addr_chg)
            r_stab <= '0;
        else if (r_stab != STAB_DONE)
            r_stab <= r_stab + 1'b1;
    end

    state_t        r_state, w_state_nx;
    logic [3:0]    r_tgt, w_tgt_nx, w_sel_nx;
    logic [GW-1:0] r_gcnt, w_gcnt_nx;

    always_ff @(posedge clk_50_MHz or negedge NRESET) begin
        if (!NRESET) begin
            r_state  <= S_IDLE;
            r_tgt    <= '0;
            r_gcnt   <= '0;
            sel_ch   <= '0;
            addr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_tgt    <= w_tgt_nx;
            r_gcnt   <= w_gcnt_nx;
            sel_ch   <= w_sel_nx;
            addr_err <= w_accept && !w_valid;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tgt_nx   = r_tgt;
        w_gcnt_nx  = r_gcnt;
        w_sel_nx   = sel_ch;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_valid) begin
                    w_state_nx = S_GUARD;
                    w_tgt_nx   = r_addr_s[3:0];
                    w_gcnt_nx  = GUARD_LOAD;
                end
            end
            S_GUARD: begin
                if (w_accept) begin
                    if (w_valid) begin
                        w_tgt_nx  = r_addr_s[3:0];
                        w_gcnt_nx = GUARD_LOAD;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else if (r_gcnt == '0) begin
                    w_state_nx = S_ACTIVE;
                    w_sel_nx   = r_tgt;
                end else begin
                    w_gcnt_nx = r_gcnt - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_accept) begin
                    if (!w_valid) begin
                        w_state_nx = S_IDLE;
                    end else if (r_addr_s[3:0] != sel_ch) begin
                        w_state_nx = S_GUARD;
                        w_tgt_nx   = r_addr_s[3:0];
                        w_gcnt_nx  = GUARD_LOAD;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign sel_valid = (r_state == S_ACTIVE);
    assign switching = (r_state == S_GUARD);

    // One-hot of the live channel; all-zero outside ACTIVE keeps every line idle.
    logic [NUM_CH-1:0] w_sel_oh;
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_sel_oh[i] = (r_state == S_ACTIVE) && (sel_ch == 4'(i));
    end

    always_ff @(posedge clk_50_MHz or negedge NRESET) begin
        if (!NRESET) begin
            dout_osn    <= {NUM_CH{IDLE_LVL}};
            dout_rez    <= {NUM_CH{IDLE_LVL}};
            dataout_osn <= IDLE_LVL;
            dataout_rez <= IDLE_LVL;
        end else begin
            dout_osn    <= (w_sel_oh & {NUM_CH{r_dino_s}}) | (~w_sel_oh & {NUM_CH{IDLE_LVL}});
            dout_rez    <= (w_sel_oh & {NUM_CH{r_dinr_s}}) | (~w_sel_oh & {NUM_CH{IDLE_LVL}});
            dataout_osn <= (|w_sel_oh) ? |(w_sel_oh & r_modo_s) : IDLE_LVL;
            dataout_rez <= (|w_sel_oh) ? |(w_sel_oh & r_modr_s) : IDLE_LVL;
        end
    end

`ifdef UKS_ACTIVITY_EN
    localparam int WW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYC - 1);

    logic [WW-1:0]     r_win;
    logic [NUM_CH-1:0] r_prev_osn, r_prev_rez, r_seen, w_edge;

    assign w_edge = (r_modo_s ^ r_prev_osn) | (r_modr_s ^ r_prev_rez);

    always_ff @(posedge clk_50_MHz or negedge NRESET) begin
        if (!NRESET) begin
            r_win      <= '0;
            r_prev_osn <= '0;
            r_prev_rez <= '0;
            r_seen     <= '0;
            activity   <= '0;
        end else begin
            r_prev_osn <= r_modo_s;
            r_prev_rez <= r_modr_s;
            if (r_win == WIN_LAST) begin
                r_win    <= '0;
                activity <= r_seen | w_edge;
                r_seen   <= '0;
            end else begin
                r_win  <= r_win + 1'b1;
                r_seen <= r_seen | w_edge;
            end
        end
    end
`else
    assign activity = '0;
`endif

endmodule
`default_nettype wire
